// File: rtl/fb_read_arbiter.sv
// rtl/fb_read_arbiter.sv - frame-buffer read-port arbiter, display priority, sampler best-effort
// Routes one-cycle-latency read data to its owner and flags sampler starvation.
module fb_read_arbiter #(
   parameter int ADDR_W       = 16,
   parameter int DATA_W       = 16,
   parameter int STARVE_LIMIT = 1024
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              disp_req,
   input  logic [ADDR_W-1:0] disp_addr,
   output logic              disp_rvalid,
   input  logic              smp_req,
   input  logic [ADDR_W-1:0] smp_addr,
   output logic              smp_gnt,
   output logic              smp_rvalid,
   output logic [DATA_W-1:0] rdata,
   output logic [ADDR_W-1:0] mem_rdaddress,
   input  logic [DATA_W-1:0] mem_q,
   output logic              smp_starved,
   input  logic              starve_clr
);

   localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
   localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

   logic              disp_tag;
   logic              smp_tag;
   logic [ADDR_W-1:0] last_addr;
   logic [CNT_W-1:0]  wait_cnt;
   logic              starved_q;

   // Grant is purely combinational so a granted address reaches the memory this cycle.
   always_comb begin
      smp_gnt       = 1'b0;
      mem_rdaddress = last_addr;
      if (reset) begin
         mem_rdaddress = '0;
      end else if (disp_req) begin
         mem_rdaddress = disp_addr;
      end else if (smp_req) begin
         smp_gnt       = 1'b1;
         mem_rdaddress = smp_addr;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         disp_tag  <= 1'b0;
         smp_tag   <= 1'b0;
         last_addr <= '0;
      end else begin
         disp_tag <= disp_req;
         smp_tag  <= smp_gnt;
         if (disp_req || smp_gnt) begin
            last_addr <= mem_rdaddress;
         end
      end
   end

   // Clear beats both the sticky set and the counter increment.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wait_cnt  <= '0;
         starved_q <= 1'b0;
      end else if (starve_clr) begin
         wait_cnt  <= '0;
         starved_q <= 1'b0;
      end else begin
         if (wait_cnt == LIMIT) begin
            starved_q <= 1'b1;
         end
         if (smp_gnt || !smp_req) begin
            wait_cnt <= '0;
         end else if (wait_cnt != LIMIT) begin
            wait_cnt <= wait_cnt + 1'b1;
         end
      end
   end

   assign disp_rvalid = disp_tag;
   assign smp_rvalid  = smp_tag;
   assign rdata       = mem_q;
   assign smp_starved = starved_q;

endmodule

// File: tb/tb_fb_read_arbiter.sv
// tb/tb_fb_read_arbiter.sv - scoreboard bench for fb_read_arbiter
// Memory model returns addr+0x1000 one cycle after the address is presented.
module tb_fb_read_arbiter;

   localparam int LIM = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        disp_req, smp_req, starve_clr;
   logic [15:0] disp_addr, smp_addr;
   logic        disp_rvalid, smp_gnt, smp_rvalid, smp_starved;
   logic [15:0] rdata, mem_rdaddress;
   logic [15:0] mem_q = 16'h0;

   typedef struct {
      bit          d;
      bit          s;
      logic [15:0] data;
   } exp_t;

   exp_t        sb[$];
   int          n_checks = 0;
   int          n_fail   = 0;
   logic [15:0] m_last   = 16'h0;
   int          m_cnt    = 0;
   bit          m_starved = 1'b0;

   fb_read_arbiter #(.ADDR_W(16), .DATA_W(16), .STARVE_LIMIT(LIM)) dut (
      .clk(clk), .reset(reset),
      .disp_req(disp_req), .disp_addr(disp_addr), .disp_rvalid(disp_rvalid),
      .smp_req(smp_req), .smp_addr(smp_addr), .smp_gnt(smp_gnt), .smp_rvalid(smp_rvalid),
      .rdata(rdata), .mem_rdaddress(mem_rdaddress), .mem_q(mem_q),
      .smp_starved(smp_starved), .starve_clr(starve_clr)
   );

   always #5 clk = ~clk;

   always @(posedge clk) mem_q <= mem_rdaddress + 16'h1000;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic push_none();
      exp_t e;
      e.d = 1'b0; e.s = 1'b0; e.data = 16'h0;
      sb.push_back(e);
   endtask

   task automatic model_reset();
      sb.delete();
      push_none();
      m_last = 16'h0; m_cnt = 0; m_starved = 1'b0;
   endtask

   // One cycle: drive at posedge+1, compare mid-cycle, then advance past the edge.
   task automatic step(input bit d, input logic [15:0] da, input bit s,
                       input logic [15:0] sa, input bit clr);
      exp_t        e, cur;
      bit          g;
      logic [15:0] a;
      disp_req = d; disp_addr = da; smp_req = s; smp_addr = sa; starve_clr = clr;
      #3;
      if (sb.size() == 0) begin
         check("sb_empty", 32'(1), 32'(0));
         e.d = 1'b0; e.s = 1'b0; e.data = 16'h0;
      end else begin
         e = sb.pop_front();
      end
      check("disp_rvalid", 32'(disp_rvalid), 32'(e.d));
      check("smp_rvalid", 32'(smp_rvalid), 32'(e.s));
      if (e.d || e.s) check("rdata", 32'(rdata), 32'(e.data));
      g = s && !d;
      a = d ? da : (g ? sa : m_last);
      check("smp_gnt", 32'(smp_gnt), 32'(g));
      check("mem_rdaddress", 32'(mem_rdaddress), 32'(a));
      check("smp_starved", 32'(smp_starved), 32'(m_starved));
      cur.d = d; cur.s = g; cur.data = a + 16'h1000;
      sb.push_back(cur);
      if (d || g) m_last = a;
      if (clr) begin
         m_cnt = 0; m_starved = 1'b0;
      end else begin
         if (m_cnt == LIM) m_starved = 1'b1;
         if (g || !s) m_cnt = 0;
         else if (m_cnt < LIM) m_cnt++;
      end
      @(posedge clk); #1;
   endtask

   task automatic idle();
      step(1'b0, 16'h0, 1'b0, 16'h0, 1'b0);
   endtask

   initial begin
      reset = 1'b1; disp_req = 1'b0; disp_addr = 16'h0;
      smp_req = 1'b1; smp_addr = 16'h5555; starve_clr = 1'b0;
      #12;
      check("rst_disp_rvalid", 32'(disp_rvalid), 32'(0));
      check("rst_smp_rvalid", 32'(smp_rvalid), 32'(0));
      check("rst_smp_gnt", 32'(smp_gnt), 32'(0));
      check("rst_starved", 32'(smp_starved), 32'(0));
      check("rst_addr", 32'(mem_rdaddress), 32'(0));
      @(posedge clk); #1;
      reset = 1'b0; smp_req = 1'b0;
      model_reset();

      // Display only
      for (int i = 0; i < 4; i++) step(1'b1, 16'h0010 + 16'(i), 1'b0, 16'h0, 1'b0);
      idle();

      // Collision, then sampler once display drops
      step(1'b1, 16'h0100, 1'b1, 16'h0200, 1'b0);
      step(1'b0, 16'h0100, 1'b1, 16'h0200, 1'b0);
      idle();

      // Sampler burst with address wrap
      step(1'b0, 16'h0, 1'b1, 16'hFFFE, 1'b0);
      step(1'b0, 16'h0, 1'b1, 16'hFFFF, 1'b0);
      step(1'b0, 16'h0, 1'b1, 16'h0000, 1'b0);
      idle();

      // Idle hold
      step(1'b1, 16'h1234, 1'b0, 16'h0, 1'b0);
      for (int i = 0; i < 3; i++) idle();

      // Starvation: 5 denied cycles, sticky after display drops
      for (int i = 0; i < 5; i++) step(1'b1, 16'h0300 + 16'(i), 1'b1, 16'h0400, 1'b0);
      step(1'b0, 16'h0, 1'b1, 16'h0400, 1'b0);
      idle();
      check("starved_sticky", 32'(smp_starved), 32'(1));
      // Clear while denied, then confirm the counter restarted from zero
      step(1'b1, 16'h0500, 1'b1, 16'h0600, 1'b1);
      check("starved_cleared", 32'(smp_starved), 32'(0));
      for (int i = 0; i < 3; i++) step(1'b1, 16'h0500, 1'b1, 16'h0600, 1'b0);
      step(1'b1, 16'h0500, 1'b1, 16'h0600, 1'b1);
      for (int i = 0; i < 6; i++) step(1'b1, 16'h0510 + 16'(i), 1'b1, 16'h0600, 1'b0);
      step(1'b0, 16'h0, 1'b0, 16'h0, 1'b1);
      idle();

      // Reset mid-read
      step(1'b0, 16'h0, 1'b1, 16'h0042, 1'b0);
      check("pre_rst_rvalid", 32'(smp_rvalid), 32'(1));
      reset = 1'b1;
      #1;
      check("async_rvalid_drop", 32'(smp_rvalid), 32'(0));
      check("rst_gnt_forced", 32'(smp_gnt), 32'(0));
      check("rst_addr_zero", 32'(mem_rdaddress), 32'(0));
      @(posedge clk); #1;
      reset = 1'b0;
      model_reset();
      step(1'b0, 16'h0, 1'b1, 16'h0077, 1'b0);
      idle();
      idle();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
